// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART transmitter; start, 8 data bits LSB first, parity, stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int   CLKS_PER_BIT = 16,
    parameter logic PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TxData,
    input  logic       tx_start,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int               c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
    localparam logic [2:0] c_parity = 3'd3;
    localparam logic [2:0] c_stop   = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_data;
    logic               r_txd;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [2:0]         w_idx_next;
    logic [7:0]         w_data_next;
    logic               w_bit_end;
    logic               w_txd_next;
    logic               w_busy_next;
    logic               w_done_next;

    assign w_bit_end = (r_cnt == c_cnt_last);

    // Outputs are registered from next-state values so TxD changes on the
    // same edge that changes state, with no combinational path from inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_data  <= 8'd0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_data  <= w_data_next;
            r_txd   <= w_txd_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_data_next  = r_data;
        case (r_state)
            c_idle: begin
                w_cnt_next = '0;
                if (tx_start) begin
                    w_state_next = c_start;
                    w_data_next  = TxData;
                end
            end
            c_start, c_data, c_parity, c_stop: begin
                w_cnt_next = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    case (r_state)
                        c_start: begin
                            w_state_next = c_data;
                            w_idx_next   = 3'd0;
                        end
                        c_data: begin
                            w_idx_next = r_idx + 3'd1;
                            if (r_idx == 3'd7) begin
                                w_state_next = c_parity;
                            end
                        end
                        c_parity: w_state_next = c_stop;
                        default:  w_state_next = c_idle;
                    endcase
                end
            end
            default: begin
                w_state_next = c_idle;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            c_start:  w_txd_next = 1'b0;
            c_data:   w_txd_next = w_data_next[w_idx_next];
            c_parity: w_txd_next = (^w_data_next) ^ PARITY_ODD;
            default:  w_txd_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != c_idle);
        w_done_next = (r_state == c_stop) && (w_state_next == c_idle);
    end

    assign TxD     = r_txd;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; must match the receiver's 16-clock bit period.
REQ-002 Parameter PARITY_ODD, default 0, parity sense: 0 selects even parity, 1 selects odd parity.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 Port TxData  input  8  byte to transmit; sampled only when a start is accepted.
REQ-006 Port tx_start  input  1  transmit request; level-sampled each cycle.
REQ-007 Port TxD  output  1  serial line; idle high.
REQ-008 Port tx_busy  output  1  high while a frame is in progress (START through STOP).
REQ-009 Port tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 Frame SHALL be 11 bits: start (0), 8 data bits LSB first, parity, stop (1).
REQ-011 Each bit SHALL hold TxD for exactly CLKS_PER_BIT cycles, so a full frame is 11*CLKS_PER_BIT cycles (176 at default).
REQ-012 State machine SHALL have states IDLE, START, DATA, PARITY and STOP, all registered.
REQ-013 IDLE: TxD=1 and tx_busy=0; if tx_start=1 at a rising edge, TxData SHALL be latched into an internal shift register and the state SHALL move to START.
REQ-014 Latency: TxD SHALL go to 0 in the cycle immediately after the edge that accepted tx_start; tx_busy SHALL rise in the same cycle.
REQ-015 START SHALL last CLKS_PER_BIT cycles and then go to DATA with bit index 0.
REQ-016 DATA SHALL drive latched bit[index]; after CLKS_PER_BIT cycles the index SHALL increment, and after bit 7 the state SHALL go to PARITY.
REQ-017 PARITY SHALL drive (XOR of the 8 latched bits) XOR PARITY_ODD; e.g. with even parity 0xAA gives 0 and 0x8A gives 1.
REQ-018 STOP SHALL drive 1 for CLKS_PER_BIT cycles and then go to IDLE.
REQ-019 tx_done SHALL be 1 for exactly the first IDLE cycle after STOP, and 0 at all other times.
REQ-020 tx_busy SHALL fall in that same cycle.
REQ-021 A tx_start asserted while tx_busy=1 SHALL be ignored, with no queuing.
REQ-022 Changes to TxData during a frame SHALL have no effect on that frame.
REQ-023 Back-to-back frames: a tx_start held high continuously SHALL be accepted in the first IDLE cycle (the tx_done cycle), giving exactly one idle-high cycle between the stop bit and the next start bit.
REQ-024 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-025 Bit index SHALL be 3 bits and SHALL be cleared on entry to DATA.
REQ-026 TxD SHALL be driven from a register, so it is glitch-free with no combinational path from the inputs.

Reset
REQ-027 When reset=0 at a rising edge, the block SHALL enter IDLE with TxD=1, tx_busy=0, tx_done=0, the bit counter at 0, the index at 0 and the shift register at 0.
REQ-028 Reset SHALL have priority over tx_start.
REQ-029 Reset asserted mid-frame SHALL abort the frame: TxD=1 from the next cycle, and no tx_done for the aborted frame.
REQ-030 After reset is released, the first tx_start SHALL produce a complete, correct frame.

Verification
REQ-031 Reset check: hold reset=0 for 16 cycles with tx_start=1 -> TxD=1, tx_busy=0, tx_done=0 throughout.
REQ-032 Basic frame: TxData=0x8A, 1-cycle tx_start -> TxD sampled at the centre of each 16-cycle bit reads 0,0,1,0,1,0,0,0,1,1,1; tx_done pulses once, 176 cycles after the first start-bit cycle.
REQ-033 Parity check: send 0xAA and 0xFF with PARITY_ODD=0 -> parity bit 0 in both cases; repeat with PARITY_ODD=1 -> parity bit 1.
REQ-034 Busy rejection: pulse tx_start at cycle 50 of a frame with TxData=0x55 -> no second frame; data of the first frame is unchanged.
REQ-035 Back-to-back: hold tx_start=1 with 0x01 then 0x80 -> two frames separated by exactly 1 idle-high cycle; the receiver bench reports valid_rx with 0x01 then 0x80 and no parity or stop error.
REQ-036 Mid-frame reset: assert reset during DATA bit 3 -> TxD=1 next cycle; no tx_done; a following 0x3C frame is correct.
